fetch_queue: RTL

Parametrised successor to the single-cycle fetch stage: decouples instruction-memory access from decode with a DEPTH-entry prefetch queue and a valid/ready handshake toward decode. Redirects (branch/jump, return, interrupt) flush the queue and squash the in-flight memory response. The two-step return-address assembly from popped stack words is built in. Sits between instruction memory and the IF/ID boundary.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the fetch queue: redirect source encodings,
// the bubble instruction and the queue entry width helper.
package fetch_pkg;

  localparam logic [1:0] REDIR_TGT = 2'b00;
  localparam logic [1:0] REDIR_RET = 2'b01;
  localparam logic [1:0] REDIR_ISR = 2'b10;

  localparam int NOP = 0;

  function automatic int entry_bits(input int w, input int aw);
    return w + aw;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular FIFO of {instr, pc} with synchronous flush.
// Flush wins over push/pop; full+push+pop is legal (head read pre-edge).
module fetch_fifo import fetch_pkg::*; #(
  parameter int W     = 16,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_instr,
  input  logic [AW-1:0]            push_pc,
  input  logic                     pop,
  output logic [W-1:0]             head_instr,
  output logic [AW-1:0]            head_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_bits(W, AW);

  typedef struct packed {
    logic [W-1:0]  instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_q] <= EW'({push_instr, push_pc});
    end
  end

  assign head       = mem_q[rd_q];
  assign head_instr = head.instr;
  assign head_pc    = head.pc;
  assign count      = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue between instruction memory and decode, with redirect
// squash and return-register assembly. ISR vector enabled by FETCH_INT_EN.
module fetch_queue import fetch_pkg::*; #(
  parameter int            W          = 16,
  parameter int            AW         = 32,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] START_ADDR = '0,
  parameter logic [AW-1:0] ISR_ADDR   = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [W-1:0]  imem_rdata,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [W-1:0]  dec_instr,
  output logic [AW-1:0] dec_pc,
  output logic [AW-1:0] dec_pc_1,
  input  logic          redir_valid,
  input  logic [1:0]    redir_src,
  input  logic [AW-1:0] redir_target,
  input  logic          pop_valid,
  input  logic          pop_hi,
  input  logic [W-1:0]  pop_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]  pc_q, pc_d;
  logic [2*W-1:0] ret_q, ret_d;
  logic           inflight_q;
  logic           req_epoch_q;
  logic           epoch_q;

  logic [CW-1:0]  count;
  logic [CW:0]    used;
  logic [AW-1:0]  tgt;
  logic [W-1:0]   head_instr;
  logic [AW-1:0]  head_pc;
  logic           resp_ok;
  logic           deq;

  // Credit: queued plus outstanding never exceeds DEPTH.
  assign used     = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign imem_req = !rst && !redir_valid
                 && (used < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;

  assign resp_ok = inflight_q && (req_epoch_q == epoch_q);
  assign deq     = dec_valid && dec_ready;

  always_comb begin
    tgt = redir_target;
    case (redir_src)
      REDIR_TGT: tgt = redir_target;
      REDIR_RET: tgt = ret_q[AW-1:0];
`ifdef FETCH_INT_EN
      REDIR_ISR: tgt = ISR_ADDR;
`endif
      default:   tgt = redir_target;
    endcase
  end

`ifndef FETCH_INT_EN
  logic unused_isr;
  assign unused_isr = ^ISR_ADDR;
`endif

  always_comb begin
    pc_d = pc_q;
    if (redir_valid) pc_d = tgt;
    else if (imem_req) pc_d = pc_q + AW'(1);
  end

  always_comb begin
    ret_d = ret_q;
    if (pop_valid) begin
      if (pop_hi) ret_d = {pop_data, W'(0)};
      else        ret_d = {ret_q[2*W-1:W], pop_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= START_ADDR;
      ret_q       <= '0;
      inflight_q  <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ret_q       <= ret_d;
      inflight_q  <= imem_req;
      req_epoch_q <= epoch_q;
      epoch_q     <= epoch_q ^ redir_valid;
    end
  end

  fetch_fifo #(
    .W     (W),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redir_valid),
    .push       (resp_ok),
    .push_instr (imem_rdata),
    .push_pc    (pc_q - AW'(1)),
    .pop        (deq),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign dec_valid = (count != '0);
  assign dec_instr = dec_valid ? head_instr : W'(NOP);
  assign dec_pc    = dec_valid ? head_pc : '0;
  assign dec_pc_1  = dec_pc + AW'(1);

endmodule
